// File: rtl/lcd_init_pkg.sv
// Shared definitions for the ST7735 init sequencer: FSM encoding, the fixed
// command table and the parameter-byte budget held in the init BRAM.
package lcd_init_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_FETCH,
    ST_WAIT,
    ST_PARAM,
    ST_DELAY,
    ST_NEXT,
    ST_DONE
  } state_t;

  localparam int CMD_COUNT   = 21;
  localparam int CMD_IDX_W   = $clog2(CMD_COUNT);
  localparam int PARAM_TOTAL = 67;

  localparam logic [7:0] OP_SWRESET = 8'h01;
  localparam logic [7:0] OP_SLPOUT  = 8'h11;
  localparam logic [7:0] OP_FRMCTR1 = 8'hB1;
  localparam logic [7:0] OP_FRMCTR2 = 8'hB2;
  localparam logic [7:0] OP_FRMCTR3 = 8'hB3;
  localparam logic [7:0] OP_INVCTR  = 8'hB4;
  localparam logic [7:0] OP_PWCTR1  = 8'hC0;
  localparam logic [7:0] OP_PWCTR2  = 8'hC1;
  localparam logic [7:0] OP_PWCTR3  = 8'hC2;
  localparam logic [7:0] OP_PWCTR4  = 8'hC3;
  localparam logic [7:0] OP_PWCTR5  = 8'hC4;
  localparam logic [7:0] OP_VMCTR1  = 8'hC5;
  localparam logic [7:0] OP_GMCTRP1 = 8'hE0;
  localparam logic [7:0] OP_GMCTRN1 = 8'hE1;
  localparam logic [7:0] OP_PWCTR6  = 8'hFC;
  localparam logic [7:0] OP_COLMOD  = 8'h3A;
  localparam logic [7:0] OP_MADCTL  = 8'h36;
  localparam logic [7:0] OP_CASET   = 8'h2A;
  localparam logic [7:0] OP_RASET   = 8'h2B;
  localparam logic [7:0] OP_DISPON  = 8'h29;
  localparam logic [7:0] OP_RAMWR   = 8'h2C;

  localparam logic [7:0] OPCODES [CMD_COUNT] = '{
    OP_SWRESET, OP_SLPOUT,
    OP_FRMCTR1, OP_FRMCTR2, OP_FRMCTR3, OP_INVCTR,
    OP_PWCTR1, OP_PWCTR2, OP_PWCTR3, OP_PWCTR4, OP_PWCTR5, OP_VMCTR1,
    OP_GMCTRP1, OP_GMCTRN1, OP_PWCTR6,
    OP_COLMOD, OP_MADCTL, OP_CASET, OP_RASET,
    OP_DISPON, OP_RAMWR
  };

  localparam logic [4:0] NPARAMS [CMD_COUNT] = '{
    5'd0, 5'd0,
    5'd3, 5'd3, 5'd6, 5'd1,
    5'd3, 5'd1, 5'd2, 5'd2, 5'd2, 5'd1,
    5'd16, 5'd16, 5'd1,
    5'd1, 5'd1, 5'd4, 5'd4,
    5'd0, 5'd0
  };

  // Commands that need the panel to settle before anything else is sent.
  localparam logic DELAY_FLAG [CMD_COUNT] = '{
    1'b1, 1'b1,
    1'b0, 1'b0, 1'b0, 1'b0,
    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
    1'b0, 1'b0, 1'b0,
    1'b0, 1'b0, 1'b0, 1'b0,
    1'b1, 1'b0
  };

  function automatic int param_sum();
    int s = 0;
    for (int i = 0; i < CMD_COUNT; i++) s += int'(NPARAMS[i]);
    return s;
  endfunction

  localparam bit PARAM_SUM_OK = (param_sum() == PARAM_TOTAL);

endpackage

// File: rtl/lcd_delay_timer.sv
// Post-command settle timer: reloads while idle, counts down while enabled and
// flags expiry once DELAY_CYCLES counting cycles have elapsed.
module lcd_delay_timer #(
  parameter int DELAY_CYCLES = 1440000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic count,
  output logic expired
);

  localparam int CNT_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DELAY_CYCLES - 1);

  logic [CNT_W-1:0] remaining;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every reader sees the pre-edge value regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      remaining <= RELOAD;
    end else if (count && !expired) begin
      remaining <= remaining - CNT_W'(1);
    end
  end

  assign expired = (remaining == '0);

endmodule

// File: rtl/lcd_init_sequencer.sv
// ST7735 init sequencer: walks the command table, streams each opcode (dc=0)
// and its BRAM-held parameter bytes (dc=1) to the SPI byte shifter.
module lcd_init_sequencer
  import lcd_init_pkg::*;
#(
  parameter int DELAY_CYCLES = 1440000,
  parameter int ADDR_W       = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  input  logic              rd_valid,
  output logic [7:0]        tx_byte,
  output logic              tx_dc,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  if (!PARAM_SUM_OK) begin : g_param_sum_check
    $error("lcd_init_pkg: NPARAMS does not sum to PARAM_TOTAL");
  end

  localparam logic [CMD_IDX_W-1:0] LAST_CMD = CMD_IDX_W'(CMD_COUNT - 1);

  state_t               state;
  logic [CMD_IDX_W-1:0] cmd_idx;
  logic [4:0]           param_cnt;
  logic                 delay_expired;
  state_t               after_cmd;

  assign after_cmd = DELAY_FLAG[cmd_idx] ? ST_DELAY : ST_NEXT;

  lcd_delay_timer #(.DELAY_CYCLES(DELAY_CYCLES)) u_delay (
    .clk     (clk),
    .rst     (rst),
    .load    (state != ST_DELAY),
    .count   (state == ST_DELAY),
    .expired (delay_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cmd_idx   <= '0;
      param_cnt <= '0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      tx_byte   <= '0;
      tx_dc     <= 1'b0;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // Read strobe is a single-cycle pulse raised only on entry to FETCH.
      rd_en <= 1'b0;
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state   <= ST_CMD;
            cmd_idx <= '0;
            rd_addr <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        ST_CMD: begin
          if (!tx_valid) begin
            tx_byte   <= OPCODES[cmd_idx];
            tx_dc     <= 1'b0;
            tx_valid  <= 1'b1;
            param_cnt <= NPARAMS[cmd_idx];
          end else if (tx_ready) begin
            tx_valid <= 1'b0;
            if (param_cnt != '0) begin
              state <= ST_FETCH;
              rd_en <= 1'b1;
            end else begin
              state <= after_cmd;
            end
          end
        end
        ST_FETCH: state <= ST_WAIT;
        ST_WAIT: begin
          if (rd_valid) begin
            tx_byte  <= rd_data;
            tx_dc    <= 1'b1;
            tx_valid <= 1'b1;
            state    <= ST_PARAM;
          end
        end
        ST_PARAM: begin
          if (tx_ready) begin
            tx_valid  <= 1'b0;
            rd_addr   <= rd_addr + ADDR_W'(1);
            param_cnt <= param_cnt - 5'd1;
            if (param_cnt != 5'd1) begin
              state <= ST_FETCH;
              rd_en <= 1'b1;
            end else begin
              state <= after_cmd;
            end
          end
        end
        ST_DELAY: if (delay_expired) state <= ST_NEXT;
        ST_NEXT: begin
          if (cmd_idx == LAST_CMD) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cmd_idx <= cmd_idx + CMD_IDX_W'(1);
            state   <= ST_CMD;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_init_sequencer.sv
// Bench for lcd_init_sequencer: a golden byte/dc stream built from the command
// table and BRAM image, checked every cycle by a negedge monitor.
module tb_lcd_init_sequencer;

  localparam int DC = 4;
  localparam int AW = 7;
  localparam int NBYTES = 88;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data = '0;
  logic          rd_valid = 1'b0;
  logic [7:0]    tx_byte;
  logic          tx_dc;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic          busy;
  logic          done;

  int checks = 0;
  int failures = 0;

  lcd_init_sequencer #(.DELAY_CYCLES(DC), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .tx_byte(tx_byte), .tx_dc(tx_dc), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] op_tab [21] = '{8'h01, 8'h11, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hC0, 8'hC1,
                              8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hE0, 8'hE1, 8'hFC, 8'h3A,
                              8'h36, 8'h2A, 8'h2B, 8'h29, 8'h2C};
  int np_tab [21] = '{0, 0, 3, 3, 6, 1, 3, 1, 2, 2, 2, 1, 16, 16, 1, 1, 1, 4, 4, 0, 0};
  bit dl_tab [21] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
  logic [7:0] mem [67] = '{
    8'h05, 8'h3C, 8'h3C,  8'h05, 8'h3C, 8'h3C,  8'h05, 8'h3C, 8'h3C, 8'h05, 8'h3C, 8'h3C,
    8'h03,  8'h28, 8'h08, 8'h04,  8'hC0,  8'h0D, 8'h00,  8'h8D, 8'h2A,  8'h8D, 8'hEE,  8'h1A,
    8'h04, 8'h22, 8'h07, 8'h0A, 8'h2E, 8'h30, 8'h25, 8'h2A,
    8'h28, 8'h26, 8'h2E, 8'h3A, 8'h00, 8'h01, 8'h03, 8'h13,
    8'h04, 8'h16, 8'h06, 8'h0D, 8'h2D, 8'h26, 8'h23, 8'h27,
    8'h27, 8'h25, 8'h2D, 8'h3B, 8'h00, 8'h01, 8'h04, 8'h13,
    8'h80,  8'h05,  8'hC8,  8'h00, 8'h00, 8'h00, 8'h7F,  8'h00, 8'h00, 8'h00, 8'h9F};

  typedef struct packed { logic [8:0] word; logic dly; } gold_t;
  gold_t gold [$];
  logic [8:0] cap [$];

  // Init BRAM: one-cycle read latency.
  always @(posedge clk) begin
    rd_valid <= rd_en;
    if (rd_addr < 7'd67) rd_data <= mem[rd_addr];
    else                 rd_data <= 8'hEE;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic void build_gold();
    int a = 0;
    gold.delete();
    for (int i = 0; i < 21; i++) begin
      gold.push_back({1'b0, op_tab[i], dl_tab[i]});
      for (int j = 0; j < np_tab[i]; j++) begin
        gold.push_back({1'b1, mem[a], 1'b0});
        a++;
      end
    end
  endfunction

  typedef enum {PH_IDLE, PH_RUN, PH_FIN} phase_t;
  phase_t     phase = PH_IDLE;
  int         pos = 0, exp_addr = 0, gap_cnt = 0;
  bit         gap_active = 0, prev_rst = 0, prev_accept = 0, prev_stall = 0, prev_rd_en = 0;
  logic [8:0] prev_word = '0;

  always @(negedge clk) begin
    if (rst) begin
      phase = PH_IDLE; pos = 0; exp_addr = 0; gap_active = 0;
      prev_accept = 0; prev_stall = 0; prev_rd_en = 0; prev_rst = 1;
    end else begin
      if (prev_rst)
        check("reset_outputs", {rd_en, rd_addr, tx_byte, tx_dc, tx_valid, busy, done}, '0);
      if (prev_stall) begin
        check("stall_valid_held", tx_valid, 1);
        check("stall_word_held", {tx_dc, tx_byte}, prev_word);
      end
      if (prev_accept) check("valid_drop_after_accept", tx_valid, 0);
      if (tx_valid && !tx_ready) check("no_rd_en_while_stalled", rd_en, 0);
      if (prev_rd_en) check("rd_en_single_cycle", rd_en, 0);
      if (tx_valid || rd_en) check("busy_while_active", busy, 1);
      if (phase == PH_RUN) check("done_low_while_running", done, 0);
      if (rd_en) begin
        check($sformatf("rd_addr_%0d", exp_addr), rd_addr, exp_addr);
        exp_addr++;
      end
      if (gap_active) begin
        if (!tx_valid) gap_cnt++;
        else begin
          check("delay_gap_long_enough", gap_cnt >= DC + 1, 1);
          gap_active = 0;
        end
      end
      if (tx_valid && tx_ready) begin
        check("byte_within_run", (phase == PH_RUN) && (pos < NBYTES), 1);
        if (phase == PH_RUN && pos < NBYTES) begin
          check($sformatf("byte_%0d", pos), {tx_dc, tx_byte}, gold[pos].word);
          cap.push_back({tx_dc, tx_byte});
          if (gold[pos].dly) begin gap_active = 1; gap_cnt = 0; end
          pos++;
          if (pos == NBYTES) phase = PH_FIN;
        end
      end
      if (start && phase != PH_RUN) begin
        phase = PH_RUN; pos = 0; exp_addr = 0; gap_active = 0; cap.delete();
      end
      prev_stall  = tx_valid && !tx_ready;
      prev_word   = {tx_dc, tx_byte};
      prev_accept = tx_valid && tx_ready;
      prev_rd_en  = rd_en;
      prev_rst    = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, input bit rand_ready);
    int n = 0;
    while (!done && n < budget) begin
      if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    tx_ready = 1'b1;
    check({name, "_done_reached"}, done, 1);
  endtask

  task automatic check_run_end(input string name);
    check({name, "_byte_count"}, cap.size(), NBYTES);
    check({name, "_fetch_count"}, exp_addr, 67);
    check({name, "_final_rd_addr"}, rd_addr, 67);
    check({name, "_busy_low"}, busy, 0);
  endtask

  task automatic step_until_cap(input string name, input int target);
    int n = 0;
    while (cap.size() < target && n < 3000) begin step(); n++; end
    check({name, "_reached"}, cap.size() >= target, 1);
  endtask

  initial begin
    logic [8:0] snap;
    build_gold();
    check("gold_size", gold.size(), NBYTES);

    repeat (3) step();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_tx_valid", tx_valid, 0);
    rst = 1'b0;
    step();

    // Full run with the shifter always ready.
    pulse_start();
    wait_done("run_a", 2000, 1'b0);
    check_run_end("run_a");
    check("run_a_first", cap[0], 9'h001);
    check("run_a_slpout", cap[1], 9'h011);
    check("run_a_frmctr1", cap[2], 9'h0B1);
    check("run_a_p0", cap[3], 9'h105);
    check("run_a_p1", cap[4], 9'h13C);
    check("run_a_p2", cap[5], 9'h13C);
    check("run_a_dispon", cap[86], 9'h029);
    check("run_a_last", cap[87], 9'h02C);

    // Restart from DONE, ignored start while busy, stall mid GMCTRP1.
    pulse_start();
    check("restart_done_cleared", done, 0);
    check("restart_busy", busy, 1);
    step_until_cap("busy_start", 20);
    pulse_start();
    step_until_cap("stall_point", 40);
    tx_ready = 1'b0;
    for (int n = 0; n < 20 && !tx_valid; n++) step();
    check("stall_offered", tx_valid, 1);
    snap = {tx_dc, tx_byte};
    check("stall_byte", snap, 9'h10A);
    for (int k = 0; k < 5; k++) begin
      step();
      check("stall_hold_valid", tx_valid, 1);
      check("stall_hold_word", {tx_dc, tx_byte}, snap);
      check("stall_hold_rd_en", rd_en, 0);
    end
    tx_ready = 1'b1;
    wait_done("run_b", 2000, 1'b0);
    check_run_end("run_b");

    // Reset while CASET parameter 2 is being fetched.
    pulse_start();
    step_until_cap("caset_p2", 78);
    rst = 1'b1;
    step();
    check("abort_rd_en", rd_en, 0);
    check("abort_rd_addr", rd_addr, 0);
    check("abort_tx_byte", tx_byte, 0);
    check("abort_tx_dc", tx_dc, 0);
    check("abort_tx_valid", tx_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    rst = 1'b0;
    step();
    step();
    check("abort_idle_busy", busy, 0);
    pulse_start();
    wait_done("run_c", 2000, 1'b0);
    check_run_end("run_c");
    check("run_c_first", cap[0], 9'h001);
    check("run_c_caset_p2", cap[78], 9'h100);

    // Random backpressure runs.
    for (int r = 0; r < 100; r++) begin
      pulse_start();
      wait_done($sformatf("rand_%0d", r), 3000, 1'b1);
      check_run_end($sformatf("rand_%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
